// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package disp_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g}; codes 10..15 render blank.
    localparam seg_t SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
    };

    typedef enum logic {
        GUARD_S,
        DRIVE_S
    } scan_state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low segment pattern.
module bcd_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_TABLE[bcd_i];
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with guard interval,
// frame-boundary commit of new frames and leading-zero suppression.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*N_DIGITS-1:0] load_data,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic                  lz_en,
    output logic [N_DIGITS-1:0]   an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic                  frame_done
);

    localparam int unsigned CNT_W   = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W   = $clog2(N_DIGITS);
    localparam int unsigned FRAME_W = 4 * N_DIGITS;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FRAME_W-1:0]  disp_q, disp_d;
    logic [FRAME_W-1:0]  pend_q, pend_d;
    logic                pend_v_q, pend_v_d;
    scan_state_t         state_q, state_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    seg_t                seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                frame_done_q, frame_done_d;

    logic                slot_end;
    logic                frame_end;
    logic [3:0]          digit_nib;
    logic                nonzero_hi;
    logic                lz_blank;
    seg_t                dec_seg;

    // Slot/digit counters, handshake and frame commit.
    always_comb begin
        slot_end  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        frame_end = slot_end && (idx_q == IDX_W'(N_DIGITS - 1));

        cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
        end

        disp_d   = disp_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        // Commit takes priority; a transfer on the commit cycle waits one frame.
        if (frame_end && pend_v_q) begin
            disp_d   = pend_q;
            pend_v_d = 1'b0;
        end else if (load_valid && !pend_v_q) begin
            pend_d   = load_data;
            pend_v_d = 1'b1;
        end

        frame_done_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            frame_done_q <= frame_done_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= GUARD_S;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave guard on its last cycle, return at slot end.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GUARD_S: if (cnt_q == CNT_W'(GUARD - 1)) state_d = DRIVE_S;
            DRIVE_S: if (slot_end)                    state_d = GUARD_S;
            default: state_d = GUARD_S;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd_i (digit_nib),
        .seg_o (dec_seg)
    );

    // Outputs are built from next-state values so the registered pins line up with cnt/idx.
    always_comb begin
        digit_nib  = '0;
        nonzero_hi = 1'b0;
        an_d       = '1;
        dp_d       = 1'b1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                digit_nib = disp_d[4*i +: 4];
                if (state_d == DRIVE_S) begin
                    an_d[i] = 1'b0;
                    dp_d    = ~dp_mask[i];
                end
            end
            if (IDX_W'(i) >= idx_d && disp_d[4*i +: 4] != 4'd0) begin
                nonzero_hi = 1'b1;
            end
        end
        lz_blank = lz_en && (idx_d != '0) && !nonzero_hi;
        seg_d    = (state_d == DRIVE_S && !lz_blank) ? dec_seg : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an_o       = an_q;
    assign seg_o      = seg_q;
    assign dp_o       = dp_q;
    assign frame_done = frame_done_q;
    assign load_ready = ~pend_v_q;

endmodule
